// File: rtl/multi_ch_data_sync.sv
// multi_ch_data_sync
//   Destination-side synchroniser for NUM_CH independent multi-bit buses. Each channel
//   synchronises its enable through NUM_STAGES flops, detects an event (rising edge, or any
//   transition when TOGGLE_MODE=1), captures the source bus slice and presents it to the
//   consumer with a valid/ready handshake.
//
//   Build option: define DATA_SYNC_OVERRUN_EN to drop events that arrive while data is still
//   pending (ready low) and flag them on a sticky overrun bit. Without it the newest event
//   overwrites the pending data and overrun_o is tied low.
//
// Ports
//   clk_i           destination clock, all logic on posedge
//   rst_ni          synchronous active-low reset
//   unsync_bus_i    source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable_i    per-channel source enable (level/pulse or toggle)
//   sync_ready_i    per-channel consumer ready
//   overrun_clr_i   per-channel overrun clear
//   sync_bus_o      captured data, same packing as unsync_bus_i
//   sync_valid_o    captured data pending
//   enable_pulse_o  one-cycle strobe per accepted capture
//   src_ack_o       synchronised enable level (last sync stage)
//   overrun_o       sticky: event arrived while data pending and ready low
module multi_ch_data_sync #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned TOGGLE_MODE = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus_i,
    input  logic [NUM_CH-1:0]           bus_enable_i,
    input  logic [NUM_CH-1:0]           sync_ready_i,
    input  logic [NUM_CH-1:0]           overrun_clr_i,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus_o,
    output logic [NUM_CH-1:0]           sync_valid_o,
    output logic [NUM_CH-1:0]           enable_pulse_o,
    output logic [NUM_CH-1:0]           src_ack_o,
    output logic [NUM_CH-1:0]           overrun_o
);

    typedef enum logic {StIdle, StFull} state_e;

    logic [NUM_STAGES-1:0]       sync_q [NUM_CH];
    logic [NUM_CH-1:0]           prev_q;
    logic [NUM_CH-1:0]           last;
    logic [NUM_CH-1:0]           event_det;
    state_e                      state_q [NUM_CH];
    state_e                      state_d [NUM_CH];
    logic [NUM_CH*BUS_WIDTH-1:0] data_q, data_d;
    logic [NUM_CH-1:0]           pulse_q;
    logic [NUM_CH-1:0]           capture;
    logic [NUM_CH-1:0]           set_ovr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c]  <= '0;
                state_q[c] <= StIdle;
            end
            prev_q  <= '0;
            data_q  <= '0;
            pulse_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c]  <= {sync_q[c][NUM_STAGES-2:0], bus_enable_i[c]};
                prev_q[c]  <= sync_q[c][NUM_STAGES-1];
                state_q[c] <= state_d[c];
            end
            data_q  <= data_d;
            pulse_q <= capture;
        end
    end

    always_comb begin
        data_d    = data_q;
        capture   = '0;
        set_ovr   = '0;
        last      = '0;
        event_det = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            last[c]      = sync_q[c][NUM_STAGES-1];
            event_det[c] = (TOGGLE_MODE != 0) ? (last[c] ^ prev_q[c]) : (last[c] & ~prev_q[c]);
            unique case (state_q[c])
                StIdle: begin
                    if (event_det[c]) begin
                        capture[c] = 1'b1;
                        state_d[c] = StFull;
                    end
                end
                StFull: begin
                    if (sync_ready_i[c]) begin
                        // Consumer drains this cycle; a coincident event refills with no bubble.
                        if (event_det[c]) capture[c] = 1'b1;
                        else              state_d[c] = StIdle;
                    end else if (event_det[c]) begin
`ifdef DATA_SYNC_OVERRUN_EN
                        set_ovr[c] = 1'b1;
`else
                        capture[c] = 1'b1;
`endif
                    end
                end
                default: state_d[c] = StIdle;
            endcase
            if (capture[c]) begin
                data_d[c*BUS_WIDTH +: BUS_WIDTH] = unsync_bus_i[c*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

`ifdef DATA_SYNC_OVERRUN_EN
    logic [NUM_CH-1:0] ovr_q, ovr_d;

    // Set wins over a same-cycle clear so no overrun is ever lost.
    always_comb begin
        ovr_d = set_ovr | (ovr_q & ~overrun_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ovr_q <= '0;
        else         ovr_q <= ovr_d;
    end

    assign overrun_o = ovr_q;
`else
    logic [2*NUM_CH-1:0] unused_ovr;
    assign unused_ovr = {overrun_clr_i, set_ovr};
    assign overrun_o  = '0;
`endif

    always_comb begin
        sync_valid_o = '0;
        src_ack_o    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sync_valid_o[c] = (state_q[c] == StFull);
            src_ack_o[c]    = sync_q[c][NUM_STAGES-1];
        end
    end

    assign sync_bus_o     = data_q;
    assign enable_pulse_o = pulse_q;

endmodule
